// File: rtl/sm_addsub_pkg.sv
// Shared types, constants and a reference function for the bit-serial sign-magnitude adder/subtractor.
package sm_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic SEL_ADD = 1'b0;
   localparam logic SEL_SUB = 1'b1;

   // Returns the result as an integer image of the RW=w+2 bit sign-magnitude word.
   function automatic int unsigned sm_ref(input int unsigned a, input int unsigned b,
                                          input logic sel, input int w);
      int unsigned m;
      int va;
      int vb;
      int r;
      m  = int'(w - 1);
      va = int'(a % (32'd1 << m));
      vb = int'(b % (32'd1 << m));
      if (((a >> m) & 32'd1) != 32'd0) va = -va;
      if (((b >> m) & 32'd1) != 32'd0) vb = -vb;
      r = (sel == SEL_SUB) ? (va - vb) : (va + vb);
      if (r == 0) return 32'd0;
      if (r < 0) return (32'd1 << (w + 1)) | $unsigned(-r);
      return $unsigned(r);
   endfunction

endpackage

// File: rtl/sm_addsub_serial_bit.sv
// One-bit full adder/subtractor with a registered carry/borrow; clear starts a fresh chain at this bit.
module sm_serial_bit (
   input  logic clk,
   input  logic rst,
   input  logic a_bit,
   input  logic b_bit,
   input  logic sub,
   input  logic clear,
   input  logic enable,
   output logic sum_bit,
   output logic cout,
   output logic carry_q
);

   logic c_in;
   logic carry_d;

   always_comb begin
      c_in    = clear ? 1'b0 : carry_q;
      sum_bit = a_bit ^ b_bit ^ c_in;
      if (sub) cout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_in);
      else     cout = (a_bit & b_bit) | ((a_bit ^ b_bit) & c_in);
      carry_d = carry_q;
      if (enable)     carry_d = cout;
      else if (clear) carry_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) carry_q <= 1'b0;
      else     carry_q <= carry_d;
   end

endmodule

// File: rtl/sm_addsub_serial.sv
// Bit-serial sign-magnitude adder/subtractor with start/done handshake.
// Optional SM_ADDSUB_EARLY_EXIT_EN: skip the serial passes when either operand magnitude is zero.
module sm_addsub_serial #(
   parameter int W  = 3,
   parameter int RW = W + 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  num1,
   input  logic [W-1:0]  num2,
   input  logic          selection,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic [RW-1:0] result,
   output logic          zeroflag
);
   import sm_addsub_pkg::*;

   localparam int M  = W - 1;
   localparam int IW = $clog2(W);
   localparam logic [IW-1:0] LAST = IW'(M - 1);

   state_t          state_q, state_d;
   logic [M-1:0]    a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic            sa_q, sa_d, sb_q, sb_d, sel_q, sel_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [RW-1:0]   result_q, result_d;
   logic            zero_q, zero_d;

   logic            eff_sub;
   logic            bit_a, bit_b, bit_sub, bit_clear, bit_en;
   logic            sum_bit, cout, bit_carry_unused;
   logic [M:0]      cat;
   logic [M-1:0]    shifted;
   logic            load;
   logic            sign_load;
   logic [M:0]      mag_load;

   // A zero magnitude always yields the all-zero word, whatever sign was computed.
   function automatic logic [RW-1:0] pack_result(input logic s, input logic [M:0] mag);
      pack_result = '0;
      if (mag != '0) begin
         pack_result[RW-1] = s;
         pack_result[M:0]  = mag;
      end
   endfunction

   sm_serial_bit u_bit (
      .clk     (clk),
      .rst     (rst),
      .a_bit   (bit_a),
      .b_bit   (bit_b),
      .sub     (bit_sub),
      .clear   (bit_clear),
      .enable  (bit_en),
      .sum_bit (sum_bit),
      .cout    (cout),
      .carry_q (bit_carry_unused)
   );

   assign eff_sub = (sel_q == SEL_SUB) ^ sa_q ^ sb_q;
   assign cat     = {sum_bit, diff_q};
   assign shifted = cat[M:1];

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      diff_d    = diff_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      sel_d     = sel_q;
      idx_d     = idx_q;
      result_d  = result_q;
      zero_d    = zero_q;
      bit_a     = 1'b0;
      bit_b     = 1'b0;
      bit_sub   = 1'b0;
      bit_clear = 1'b0;
      bit_en    = 1'b0;
      load      = 1'b0;
      sign_load = 1'b0;
      mag_load  = '0;
      case (state_q)
         IDLE: begin
            bit_clear = 1'b1;
            if (start) begin
               a_d     = num1[M-1:0];
               b_d     = num2[M-1:0];
               sa_d    = num1[W-1];
               sb_d    = num2[W-1];
               sel_d   = selection;
               idx_d   = '0;
               diff_d  = '0;
               state_d = RUN;
`ifdef SM_ADDSUB_EARLY_EXIT_EN
               if (num2[M-1:0] == '0) begin
                  state_d   = DONE;
                  load      = 1'b1;
                  sign_load = num1[W-1];
                  mag_load  = {1'b0, num1[M-1:0]};
               end else if (num1[M-1:0] == '0) begin
                  state_d   = DONE;
                  load      = 1'b1;
                  sign_load = num2[W-1] ^ selection;
                  mag_load  = {1'b0, num2[M-1:0]};
               end
`endif
            end
         end
         RUN: begin
            bit_a   = a_q[0];
            bit_b   = b_q[0];
            bit_sub = eff_sub;
            bit_en  = 1'b1;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            diff_d  = shifted;
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST) begin
               idx_d = '0;
               // A final borrow means |A|<|B|: the difference is in two's complement and must be negated.
               if (eff_sub && cout) begin
                  state_d = NEG;
               end else begin
                  state_d   = DONE;
                  load      = 1'b1;
                  sign_load = sa_q;
                  mag_load  = eff_sub ? {1'b0, shifted} : {cout, shifted};
               end
            end
         end
         NEG: begin
            bit_b     = diff_q[0];
            bit_sub   = 1'b1;
            bit_en    = 1'b1;
            bit_clear = (idx_q == '0);
            diff_d    = shifted;
            idx_d     = idx_q + IW'(1);
            if (idx_q == LAST) begin
               idx_d     = '0;
               state_d   = DONE;
               load      = 1'b1;
               sign_load = sb_q ^ (sel_q == SEL_SUB);
               mag_load  = {1'b0, shifted};
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (load) begin
         result_d = pack_result(sign_load, mag_load);
         zero_d   = (mag_load == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         sel_q    <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         sel_q    <= sel_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign ready    = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign zeroflag = zero_q;

endmodule

// File: tb/tb_sm_addsub_serial.sv
// Self-checking bench for sm_addsub_serial (W=3): vector table, corner sequences, sweep and random ops.
module tb_sm_addsub_serial;
   import sm_addsub_pkg::*;

   localparam int W  = 3;
   localparam int RW = W + 2;
   localparam int M  = W - 1;
`ifdef SM_ADDSUB_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam int ZL = EARLY ? 1 : M;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  num1 = '0;
   logic [W-1:0]  num2 = '0;
   logic          selection = 1'b0;
   logic          ready, busy, done, zeroflag;
   logic [RW-1:0] result;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          s;
      logic [RW-1:0] res;
      logic          zf;
      int            lat;
   } vec_t;

   vec_t vecs[10];

   sm_addsub_serial #(.W(W), .RW(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num1      (num1),
      .num2      (num2),
      .selection (selection),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zeroflag  (zeroflag)
   );

   always #5 clk = ~clk;

   // Reference: signed integer arithmetic on the decoded operands.
   function automatic logic [RW-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
      int va;
      int vb;
      int r;
      va = int'(a[M-1:0]);
      vb = int'(b[M-1:0]);
      if (a[W-1]) va = -va;
      if (b[W-1]) vb = -vb;
      r = s ? va - vb : va + vb;
      if (r == 0) return '0;
      if (r < 0) return {1'b1, (RW-1)'(-r)};
      return {1'b0, (RW-1)'(r)};
   endfunction

   // Cycles from the start edge until done is visible.
   function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int ma;
      int mb;
      logic opposite;
      ma = int'(a[M-1:0]);
      mb = int'(b[M-1:0]);
      opposite = s ^ a[W-1] ^ b[W-1];
      if (EARLY && (ma == 0 || mb == 0)) return 1;
      if (opposite && ma < mb) return 2 * M;
      return M;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [RW-1:0] res, output logic zf, output int lat);
      int guard;
      guard = 0;
      while (!ready && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      num1 = a;
      num2 = b;
      selection = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      num1 = W'($urandom);
      num2 = W'($urandom);
      selection = 1'($urandom);
      lat = 0;
      res = '0;
      zf = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            res = result;
            zf = zeroflag;
            break;
         end
      end
      if (lat == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL done_timeout: got no done expected done within 20 cycles");
      end else begin
         @(posedge clk);
         #1;
         check_output("done_fall", {31'd0, done}, 32'd0);
         check_output("ready_after", {31'd0, ready}, 32'd1);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [RW-1:0] res;
      logic          zf;
      logic [RW-1:0] exp;
      int            lat;
      int            pulses;

      vecs[0] = '{3'b011, 3'b010, SEL_ADD, 5'b00101, 1'b0, 2};
      vecs[1] = '{3'b001, 3'b011, SEL_SUB, 5'b10010, 1'b0, 4};
      vecs[2] = '{3'b100, 3'b000, SEL_ADD, 5'b00000, 1'b1, ZL};
      vecs[3] = '{3'b111, 3'b111, SEL_SUB, 5'b00000, 1'b1, 2};
      vecs[4] = '{3'b110, 3'b101, SEL_SUB, 5'b10001, 1'b0, 2};
      vecs[5] = '{3'b011, 3'b111, SEL_ADD, 5'b00000, 1'b1, 2};
      vecs[6] = '{3'b011, 3'b011, SEL_ADD, 5'b00110, 1'b0, 2};
      vecs[7] = '{3'b111, 3'b011, SEL_SUB, 5'b10110, 1'b0, 2};
      vecs[8] = '{3'b001, 3'b110, SEL_ADD, 5'b10001, 1'b0, 4};
      vecs[9] = '{3'b000, 3'b101, SEL_SUB, 5'b00001, 1'b0, ZL};

      repeat (2) @(posedge clk);
      #1;
      check_output("rst_ready", {31'd0, ready}, 32'd1);
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_done", {31'd0, done}, 32'd0);
      check_output("rst_result", {27'd0, result}, 32'd0);
      check_output("rst_zf", {31'd0, zeroflag}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].s, res, zf, lat);
         check_output($sformatf("vec%0d_res", i), {27'd0, res}, {27'd0, vecs[i].res});
         check_output($sformatf("vec%0d_zf", i), {31'd0, zf}, {31'd0, vecs[i].zf});
         check_output($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      end

      // Start pulses during RUN and during DONE must both be ignored.
      num1 = 3'b110;
      num2 = 3'b101;
      selection = SEL_SUB;
      start = 1'b1;
      @(posedge clk);
      #1;
      check_output("busy_run", {31'd0, busy}, 32'd1);
      check_output("ready_run", {31'd0, ready}, 32'd0);
      num1 = 3'b011;
      num2 = 3'b011;
      selection = SEL_ADD;
      start = 1'b1;
      pulses = 0;
      res = '0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            pulses++;
            res = result;
            start = 1'b1;
         end
      end
      start = 1'b0;
      check_output("busy_ignore_pulses", pulses, 1);
      check_output("busy_ignore_res", {27'd0, res}, {27'd0, 5'b10001});

      // Reset during the second RUN cycle aborts the operation.
      apply_stimulus(3'b011, 3'b010, SEL_ADD, res, zf, lat);
      check_output("pre_abort_res", {27'd0, res}, {27'd0, 5'b00101});
      num1 = 3'b001;
      num2 = 3'b011;
      selection = SEL_SUB;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_output("abort_result", {27'd0, result}, 32'd0);
      check_output("abort_zf", {31'd0, zeroflag}, 32'd0);
      check_output("abort_ready", {31'd0, ready}, 32'd1);
      check_output("abort_busy", {31'd0, busy}, 32'd0);
      pulses = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check_output("abort_no_done", pulses, 0);
      apply_stimulus(3'b001, 3'b011, SEL_SUB, res, zf, lat);
      check_output("post_abort_res", {27'd0, res}, {27'd0, 5'b10010});
      check_output("post_abort_lat", lat, 4);

      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            for (int s = 0; s < 2; s++) begin
               exp = RW'(sm_ref(32'(a), 32'(b), 1'(s), W));
               apply_stimulus(W'(a), W'(b), 1'(s), res, zf, lat);
               check_output($sformatf("sweep_res_%0d_%0d_%0d", a, b, s), {27'd0, res}, {27'd0, exp});
               check_output($sformatf("sweep_zf_%0d_%0d_%0d", a, b, s), {31'd0, zf},
                            {31'd0, (exp == '0)});
               check_output($sformatf("sweep_lat_%0d_%0d_%0d", a, b, s), lat,
                            model_lat(W'(a), W'(b), 1'(s)));
            end
         end
      end

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rs;
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         exp = model_res(ra, rb, rs);
         apply_stimulus(ra, rb, rs, res, zf, lat);
         check_output($sformatf("rand%0d_res", i), {27'd0, res}, {27'd0, exp});
         check_output($sformatf("rand%0d_zf", i), {31'd0, zf}, {31'd0, (exp == '0)});
         check_output($sformatf("rand%0d_lat", i), lat, model_lat(ra, rb, rs));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
